// File: rtl/game_level_ctrl.sv
// Level/round/miss controller for a number-guessing game: PLAY, WIN and LOSE states, all outputs registered.
// Optional feature macro RETRY_LEVEL_EN: confirm in LOSE retries the current level instead of restarting at level 0.
module game_level_ctrl #(
  parameter int NUM_LEVELS       = 3,
  parameter int ROUNDS_PER_LEVEL = 3,
  parameter int BASE_MISSES      = 3,
  parameter int MISS_W           = 3,
  parameter int LVL_W            = 2,
  parameter int RND_W            = 4
) (
  input  logic              i_clk,
  input  logic              i_restart,
  input  logic              i_round_done,
  input  logic              i_miss,
  input  logic              i_timer_zero,
  input  logic              i_confirm,
  output logic [LVL_W-1:0]  o_level,
  output logic [LVL_W-1:0]  o_max_digit,
  output logic [1:0]        o_status,
  output logic [MISS_W-1:0] o_guesses_left,
  output logic [RND_W-1:0]  o_round_count,
  output logic              o_level_up
);

  // State codes double as the status output encoding.
  typedef enum logic [1:0] {S_PLAY = 2'b11, S_LOSE = 2'b00, S_WIN = 2'b01} state_t;

  state_t             r_state, w_nxt_state;
  logic [LVL_W-1:0]   r_level, w_nxt_level;
  logic [RND_W-1:0]   r_rnd, w_nxt_rnd;
  logic [MISS_W-1:0]  r_miss, w_nxt_miss;
  logic               r_level_up, w_nxt_lu;
  logic [LVL_W-1:0]   r_max_digit;
  logic [MISS_W-1:0]  r_gleft, w_nxt_gleft;
  logic [MISS_W-1:0]  w_limit, w_nxt_limit;

  assign w_limit     = MISS_W'(BASE_MISSES) + MISS_W'(r_level);
  assign w_nxt_limit = MISS_W'(BASE_MISSES) + MISS_W'(w_nxt_level);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_level = r_level;
    w_nxt_rnd   = r_rnd;
    w_nxt_miss  = r_miss;
    w_nxt_lu    = 1'b0;
    case (r_state)
      S_PLAY: begin
        // round_done wins over timer_zero, which wins over miss
        if (i_round_done) begin
          if (r_rnd == RND_W'(ROUNDS_PER_LEVEL - 1)) begin
            w_nxt_rnd  = '0;
            w_nxt_miss = '0;
            if (r_level == LVL_W'(NUM_LEVELS - 1)) begin
              w_nxt_state = S_WIN;
            end else begin
              w_nxt_level = r_level + LVL_W'(1);
              w_nxt_lu    = 1'b1;
            end
          end else begin
            w_nxt_rnd = r_rnd + RND_W'(1);
          end
        end else if (i_timer_zero) begin
          w_nxt_state = S_LOSE;
        end else if (i_miss) begin
          if (r_miss < w_limit) w_nxt_miss  = r_miss + MISS_W'(1);
          else                  w_nxt_state = S_LOSE;
        end
      end
      S_WIN: begin
        if (i_confirm) begin
          w_nxt_state = S_PLAY;
          w_nxt_level = '0;
          w_nxt_rnd   = '0;
          w_nxt_miss  = '0;
        end
      end
      S_LOSE: begin
        if (i_confirm) begin
          w_nxt_state = S_PLAY;
`ifdef RETRY_LEVEL_EN
          w_nxt_level = r_level;
`else
          w_nxt_level = '0;
`endif
          w_nxt_rnd   = '0;
          w_nxt_miss  = '0;
        end
      end
      default: w_nxt_state = S_PLAY;
    endcase
    w_nxt_gleft = (w_nxt_state == S_PLAY) ? (w_nxt_limit - w_nxt_miss) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_restart) begin
      r_state     <= S_PLAY;
      r_level     <= '0;
      r_rnd       <= '0;
      r_miss      <= '0;
      r_level_up  <= 1'b0;
      r_max_digit <= LVL_W'(1);
      r_gleft     <= MISS_W'(BASE_MISSES);
    end else begin
      r_state     <= w_nxt_state;
      r_level     <= w_nxt_level;
      r_rnd       <= w_nxt_rnd;
      r_miss      <= w_nxt_miss;
      r_level_up  <= w_nxt_lu;
      r_max_digit <= w_nxt_level + LVL_W'(1);
      r_gleft     <= w_nxt_gleft;
    end
  end

  assign o_level        = r_level;
  assign o_max_digit    = r_max_digit;
  assign o_status       = r_state;
  assign o_guesses_left = r_gleft;
  assign o_round_count  = r_rnd;
  assign o_level_up     = r_level_up;

endmodule

// File: tb/tb_game_level_ctrl.sv
// Scoreboard bench for game_level_ctrl at default parameters; expected snapshots are queued per stimulus cycle.
module tb_game_level_ctrl;

  logic       clk = 1'b0;
  logic       restart = 1'b0, round_done = 1'b0, miss = 1'b0, timer_zero = 1'b0, confirm = 1'b0;
  logic [1:0] level, max_digit, status;
  logic [2:0] guesses_left;
  logic [3:0] round_count;
  logic       level_up;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] md;
    logic [1:0] st;
    logic [2:0] gl;
    logic [3:0] rc;
    logic       lu;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_q[$];

  game_level_ctrl dut (
    .i_clk(clk), .i_restart(restart), .i_round_done(round_done), .i_miss(miss),
    .i_timer_zero(timer_zero), .i_confirm(confirm),
    .o_level(level), .o_max_digit(max_digit), .o_status(status),
    .o_guesses_left(guesses_left), .o_round_count(round_count), .o_level_up(level_up)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int lvl, input int st, input int gl, input int rc, input int lu);
    obs_t o;
    o.lvl = 2'(lvl);
    o.md  = 2'(lvl + 1);
    o.st  = 2'(st);
    o.gl  = 3'(gl);
    o.rc  = 4'(rc);
    o.lu  = 1'(lu);
    return o;
  endfunction

  // One clock: inputs applied after a falling edge, outputs sampled on the next falling edge.
  task automatic cyc(input logic rst_n, input logic rd, input logic ms, input logic tz,
                     input logic cf, input obs_t e);
    restart = rst_n; round_done = rd; miss = ms; timer_zero = tz; confirm = cf;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    act_q.push_back('{level, max_digit, status, guesses_left, round_count, level_up});
    restart = 1'b1; round_done = 1'b0; miss = 1'b0; timer_zero = 1'b0; confirm = 1'b0;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    cyc(0, 1, 1, 1, 1, mk(0, 3, 3, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset step%0d got lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b want lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b",
                 n, a.lvl, a.md, a.st, a.gl, a.rc, a.lu, e.lvl, e.md, e.st, e.gl, e.rc, e.lu);
      end
    end
  endtask

  task automatic test_level_up();
    cyc(0, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    cyc(1, 1, 0, 0, 0, mk(0, 3, 3, 1, 0));
    cyc(1, 1, 0, 0, 0, mk(0, 3, 3, 2, 0));
    cyc(1, 1, 0, 0, 0, mk(1, 3, 4, 0, 1));
    cyc(1, 0, 0, 0, 0, mk(1, 3, 4, 0, 0));
    cyc(1, 0, 1, 0, 0, mk(1, 3, 3, 0, 0));
    cyc(1, 0, 0, 0, 1, mk(1, 3, 3, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL level_up step%0d got lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b want lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b",
                 n, a.lvl, a.md, a.st, a.gl, a.rc, a.lu, e.lvl, e.md, e.st, e.gl, e.rc, e.lu);
      end
    end
  endtask

  task automatic test_miss_lose();
    cyc(0, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    cyc(1, 0, 1, 0, 0, mk(0, 3, 2, 0, 0));
    cyc(1, 0, 1, 0, 0, mk(0, 3, 1, 0, 0));
    cyc(1, 0, 1, 0, 0, mk(0, 3, 0, 0, 0));
    cyc(1, 0, 1, 0, 0, mk(0, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0));
    cyc(1, 0, 1, 1, 0, mk(0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 1, mk(0, 3, 3, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL miss_lose step%0d got lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b want lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b",
                 n, a.lvl, a.md, a.st, a.gl, a.rc, a.lu, e.lvl, e.md, e.st, e.gl, e.rc, e.lu);
      end
    end
  endtask

  task automatic test_priority();
    cyc(0, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    for (int i = 1; i <= 3; i++) cyc(1, 0, 1, 0, 0, mk(0, 3, 3 - i, 0, 0));
    cyc(1, 1, 1, 0, 0, mk(0, 3, 0, 1, 0));
    cyc(1, 1, 0, 1, 0, mk(0, 3, 0, 2, 0));
    cyc(1, 0, 1, 1, 0, mk(0, 0, 0, 2, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL priority step%0d got lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b want lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b",
                 n, a.lvl, a.md, a.st, a.gl, a.rc, a.lu, e.lvl, e.md, e.st, e.gl, e.rc, e.lu);
      end
    end
  endtask

  task automatic test_win();
    cyc(0, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    for (int i = 1; i <= 8; i++)
      cyc(1, 1, 0, 0, 0, mk(i / 3, 3, 3 + i / 3, i % 3, (i % 3 == 0) ? 1 : 0));
    cyc(1, 1, 0, 0, 0, mk(2, 1, 0, 0, 0));
    cyc(1, 0, 1, 0, 0, mk(2, 1, 0, 0, 0));
    cyc(1, 1, 0, 1, 0, mk(2, 1, 0, 0, 0));
    cyc(1, 0, 0, 0, 1, mk(0, 3, 3, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL win step%0d got lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b want lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b",
                 n, a.lvl, a.md, a.st, a.gl, a.rc, a.lu, e.lvl, e.md, e.st, e.gl, e.rc, e.lu);
      end
    end
  endtask

  task automatic test_timer_retry();
    cyc(0, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    for (int i = 1; i <= 3; i++) cyc(1, 1, 0, 0, 0, mk(i / 3, 3, 3 + i / 3, i % 3, (i == 3) ? 1 : 0));
    cyc(1, 0, 0, 1, 0, mk(1, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(1, 0, 0, 0, 0));
`ifdef RETRY_LEVEL_EN
    cyc(1, 0, 0, 0, 1, mk(1, 3, 4, 0, 0));
`else
    cyc(1, 0, 0, 0, 1, mk(0, 3, 3, 0, 0));
`endif
    for (int n = 0; exp_q.size() > 0; n++) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL timer_retry step%0d got lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b want lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b",
                 n, a.lvl, a.md, a.st, a.gl, a.rc, a.lu, e.lvl, e.md, e.st, e.gl, e.rc, e.lu);
      end
    end
  endtask

  task automatic test_restart_mid();
    cyc(0, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    for (int i = 1; i <= 6; i++) cyc(1, 1, 0, 0, 0, mk(i / 3, 3, 3 + i / 3, i % 3, (i % 3 == 0) ? 1 : 0));
    cyc(1, 1, 0, 0, 0, mk(2, 3, 5, 1, 0));
    cyc(1, 0, 1, 0, 0, mk(2, 3, 4, 1, 0));
    cyc(0, 1, 0, 0, 0, mk(0, 3, 3, 0, 0));
    cyc(1, 0, 0, 0, 0, mk(0, 3, 3, 0, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      obs_t e = exp_q.pop_front();
      obs_t a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL restart_mid step%0d got lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b want lvl=%0d md=%0d st=%b gl=%0d rc=%0d lu=%b",
                 n, a.lvl, a.md, a.st, a.gl, a.rc, a.lu, e.lvl, e.md, e.st, e.gl, e.rc, e.lu);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_level_up();
    test_miss_lose();
    test_priority();
    test_win();
    test_timer_retry();
    test_restart_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
